// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered on accept; the result is held until the owner consumes it.
module alu_arbiter #(
  parameter int WIDTH      = 32,
  parameter int PRIO_RESET = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_cont,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_cont,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_bge,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_cont,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_bge,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic PRIO_INIT = (PRIO_RESET != 0);

  logic [1:0]       state;
  logic             prio;
  logic             owner;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       cont_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             bge_q;

  logic idle;
  logic g0;
  logic g1;
  logic own_rdy;

  assign idle = (state == IDLE);

  // prio only matters when both are valid
  assign g0 = req0_valid & (~req1_valid | ~prio);
  assign g1 = req1_valid & (~req0_valid | prio);

  // reset_n gate keeps ready low while reset is held
  assign req0_ready = reset_n & idle & g0;
  assign req1_ready = reset_n & idle & g1;

  assign own_rdy = owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      prio   <= PRIO_INIT;
      owner  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      cont_q <= 3'b000;
      res_q  <= '0;
      zero_q <= 1'b0;
      bge_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (g0 | g1) begin
            state  <= EXEC;
            owner  <= g1;
            prio   <= ~g1;
            a_q    <= g1 ? req1_a : req0_a;
            b_q    <= g1 ? req1_b : req0_b;
            cont_q <= g1 ? req1_cont : req0_cont;
          end
        end
        EXEC: begin
          res_q  <= alu_result;
          zero_q <= alu_zero;
          bge_q  <= alu_bge;
          state  <= RESP;
        end
        RESP: begin
          if (own_rdy)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_cont   = cont_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_bge    = bge_q;
  assign rsp0_valid = (state == RESP) & ~owner;
  assign rsp1_valid = (state == RESP) & owner;
  assign busy       = ~idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: local ALU model, scoreboard queue of expected
// responses pushed on accept and popped on consume.
module tb_alu_arbiter;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   cont;
    logic [W-1:0] res;
    logic         zero;
    logic         bge;
  } op_t;

  typedef struct {
    logic         owner;
    logic [W-1:0] res;
    logic         zero;
    logic         bge;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req0_valid = 1'b0;
  logic         req1_valid = 1'b0;
  logic         req0_ready;
  logic         req1_ready;
  logic [W-1:0] req0_a = '0;
  logic [W-1:0] req0_b = '0;
  logic [W-1:0] req1_a = '0;
  logic [W-1:0] req1_b = '0;
  logic [2:0]   req0_cont = '0;
  logic [2:0]   req1_cont = '0;
  logic         rsp0_valid;
  logic         rsp1_valid;
  logic         rsp0_ready = 1'b1;
  logic         rsp1_ready = 1'b1;
  logic [W-1:0] rsp_result;
  logic         rsp_zero;
  logic         rsp_bge;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_cont;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic         alu_bge;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [1:0] prev_rv = 2'b00;

  op_t  cur0;
  op_t  cur1;
  op_t  q0[$];
  op_t  q1[$];
  exp_t exp_q[$];
  int   grant_log[$];
  int   acc_log[$];

  alu_arbiter #(.WIDTH(W), .PRIO_RESET(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cont(req0_cont),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cont(req1_cont),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_bge(rsp_bge),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cont(alu_cont),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_bge(alu_bge),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] alu_ref(logic [W-1:0] a, logic [W-1:0] b,
                                           logic [2:0] c);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_a, alu_b, alu_cont);
  assign alu_zero   = (alu_result == '0);
  assign alu_bge    = ~alu_result[W-1];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic op_t dir_op(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] c,
                                 logic [W-1:0] r, logic z, logic g);
    op_t o;
    o.a = a; o.b = b; o.cont = c; o.res = r; o.zero = z; o.bge = g;
    return o;
  endfunction

  function automatic op_t rnd_op();
    logic [2:0] codes [5];
    logic [W-1:0] r;
    op_t o;
    codes[0] = 3'b000; codes[1] = 3'b001; codes[2] = 3'b010;
    codes[3] = 3'b110; codes[4] = 3'b111;
    o.a = $urandom; o.b = $urandom;
    o.cont = codes[$urandom_range(0, 4)];
    r = alu_ref(o.a, o.b, o.cont);
    o.res = r; o.zero = (r == '0); o.bge = ~r[W-1];
    return o;
  endfunction

  task automatic load0(op_t o);
    cur0 = o; req0_a = o.a; req0_b = o.b; req0_cont = o.cont; req0_valid = 1'b1;
  endtask

  task automatic load1(op_t o);
    cur1 = o; req1_a = o.a; req1_b = o.b; req1_cont = o.cont; req1_valid = 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        exp_t e;
        chk("one_ready", {62'd0, req1_ready, req0_ready} == 64'd3, 64'd0);
        e.owner = req1_ready;
        e.res  = req1_ready ? cur1.res : cur0.res;
        e.zero = req1_ready ? cur1.zero : cur0.zero;
        e.bge  = req1_ready ? cur1.bge : cur0.bge;
        exp_q.push_back(e);
        grant_log.push_back(int'(req1_ready));
        acc_log.push_back(cyc);
        last_acc = cyc;
      end
      if ({rsp1_valid, rsp0_valid} != 2'b00 && prev_rv == 2'b00) begin
        chk("rsp_latency", 64'(cyc - last_acc), 64'd2);
        chk("rsp_excl", {62'd0, rsp1_valid, rsp0_valid} == 64'd3, 64'd0);
      end
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_owner", 64'(rsp1_valid), 64'(e.owner));
          chk("rsp_result", 64'(rsp_result), 64'(e.res));
          chk("rsp_zero", 64'(rsp_zero), 64'(e.zero));
          chk("rsp_bge", 64'(rsp_bge), 64'(e.bge));
        end
      end
      prev_rv <= {rsp1_valid, rsp0_valid};
    end else begin
      prev_rv <= 2'b00;
    end
  end

  task automatic pump(int budget);
    int c;
    bit a0;
    bit a1;
    c = 0;
    if (!req0_valid && q0.size() > 0) load0(q0.pop_front());
    if (!req1_valid && q1.size() > 0) load1(q1.pop_front());
    while ((q0.size() > 0 || q1.size() > 0 || req0_valid || req1_valid ||
            exp_q.size() > 0 || busy) && c < budget) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (a0) begin
        if (q0.size() > 0) load0(q0.pop_front());
        else req0_valid = 1'b0;
      end
      if (a1) begin
        if (q1.size() > 0) load1(q1.pop_front());
        else req1_valid = 1'b0;
      end
      c++;
    end
    if (c >= budget) chk("timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_rdy0(string tag);
    int i;
    for (i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req0_ready) break;
    end
    if (i == 10) chk(tag, 64'd0, 64'd1);
  endtask

  initial begin
    // reset values while both requesters already wait
    load0(rnd_op());
    load1(rnd_op());
    #12;
    chk("rst_ready0", 64'(req0_ready), 64'd0);
    chk("rst_ready1", 64'(req1_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rspv", 64'({rsp1_valid, rsp0_valid}), 64'd0);
    chk("rst_result", 64'(rsp_result), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_cont", 64'(alu_cont), 64'd0);

    // contention: four ops each, both valid from reset
    for (int i = 0; i < 3; i++) q0.push_back(rnd_op());
    for (int i = 0; i < 3; i++) q1.push_back(rnd_op());
    grant_log.delete();
    acc_log.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    pump(100);
    chk("cont_count", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk("cont_owner", 64'(grant_log[i]), 64'(i % 2));
    for (int i = 1; i < acc_log.size(); i++)
      chk("cont_interval", 64'(acc_log[i] - acc_log[i-1]), 64'd3);

    // single add
    q0.push_back(dir_op(5, 7, 3'b010, 12, 1'b0, 1'b1));
    pump(30);

    // subtract / slt / equal subtract
    q1.push_back(dir_op(3, 5, 3'b110, 32'hFFFF_FFFE, 1'b0, 1'b0));
    q1.push_back(dir_op(3, 5, 3'b111, 1, 1'b0, 1'b1));
    q1.push_back(dir_op(9, 9, 3'b110, 0, 1'b1, 1'b1));
    pump(40);

    // unsupported code
    q0.push_back(dir_op(32'hFFFF, 1, 3'b011, 0, 1'b1, 1'b1));
    pump(30);

    // back-pressure on requester 0
    rsp0_ready = 1'b0;
    @(posedge clk);
    #1 load0(dir_op(20, 22, 3'b010, 42, 1'b0, 1'b1));
    wait_rdy0("bp_accept");
    @(posedge clk);
    #1 req0_valid = 1'b0;
    load1(dir_op(100, 1, 3'b110, 99, 1'b0, 1'b1));
    begin
      int i;
      for (i = 0; i < 10; i++) begin
        @(negedge clk);
        if (rsp0_valid) break;
      end
      if (i == 10) chk("bp_rsp_wait", 64'd0, 64'd1);
    end
    for (int k = 0; k < 4; k++) begin
      chk("bp_result", 64'(rsp_result), 64'd42);
      chk("bp_busy", 64'(busy), 64'd1);
      chk("bp_req1_ready", 64'(req1_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp0_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_grant1", 64'(req1_ready), 64'd1);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    pump(30);

    // reset in the middle of EXEC
    @(posedge clk);
    #1 load0(dir_op(1, 2, 3'b010, 3, 1'b0, 1'b1));
    wait_rdy0("rx_accept");
    @(posedge clk);
    #1 req0_valid = 1'b0;
    #2 reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rx_ready0", 64'(req0_ready), 64'd0);
    chk("rx_ready1", 64'(req1_ready), 64'd0);
    chk("rx_rspv", 64'({rsp1_valid, rsp0_valid}), 64'd0);
    chk("rx_busy", 64'(busy), 64'd0);
    chk("rx_cont", 64'(alu_cont), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rx_no_rsp", 64'(rsp0_valid), 64'd0);
    end
    grant_log.delete();
    @(posedge clk);
    #1;
    q0.push_back(rnd_op());
    q1.push_back(rnd_op());
    pump(40);
    chk("rx_prio", 64'(grant_log.size() > 0 ? grant_log[0] : 9), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter that shares one combinational `alu` instance between independent datapath clients, for example the main execute path and an address/branch-compare helper. It accepts one operation at a time over a valid/ready handshake, drives the shared ALU from registered operands, captures result and flags, and returns them to the owning requester with response back-pressure.

## Interface
- `WIDTH`, 32: operand/result width; must match the ALU.
- `PRIO_RESET`, 0: requester that wins the first simultaneous contention after reset (0 or 1).

- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  request pending.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle when high together with valid.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands.
- `req0_cont`, `req1_cont`  in  3  ALU control code.
- `rsp0_valid`, `rsp1_valid`  out  1  response held for that requester.
- `rsp0_ready`, `rsp1_ready`  in  1  requester consumes the response.
- `rsp_result`  out  WIDTH  captured ALU result, shared and qualified by `rspN_valid`.
- `rsp_zero`, `rsp_bge`  out  1  captured ALU flags.
- `alu_a`, `alu_b`  out  WIDTH  to ALU operand inputs.
- `alu_cont`  out  3  to ALU control.
- `alu_result`  in  WIDTH  from ALU.
- `alu_zero`, `alu_bge`  in  1  from ALU.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states:
  - IDLE to EXEC on any accepted request.
  - EXEC to RESP unconditionally.
  - RESP to IDLE when the owner's `rspN_ready` is high.
- Readiness:
  - `reqN_ready` is combinational and high only in IDLE, for the granted requester only.
  - At most one ready is high per cycle.
- Grant in IDLE:
  - One valid: grant that requester.
  - Both valid: grant requester `prio`.
  - After any grant, `prio` becomes the other requester.
  - `prio` resets to `PRIO_RESET`.
- On accept, register the operands, `cont` and the owner tag. `alu_a`/`alu_b`/`alu_cont` always drive these registers.
- In EXEC, capture `alu_result`, `alu_zero` and `alu_bge` into the response registers.
- In RESP, `rspN_valid` is high for the owner only. Result and flags are held stable until consumed.
- `alu_cont` codes are forwarded unmodified. For unsupported codes (011, 100, 101) the ALU returns 0, so the response is result 0, zero 1, bge 1. The arbiter does not flag these as errors.
- Operand registers keep their last value outside EXEC.
- Requests arriving while not in IDLE wait; the requester must hold valid and payload stable.
- Reset values:
  - State: IDLE.
  - `prio`: `PRIO_RESET`.
  - Operand registers: 0.
  - `alu_cont`: 3'b000.
  - Response registers: 0.
  - All `reqN_ready`, all `rspN_valid`, and `busy`: 0.
- Reset asserted mid-operation discards the transaction; no response is ever produced for it.

## Timing
- Request accepted at edge T (valid and ready high in cycle T-1).
- EXEC occupies cycle T to T+1; the result is captured at edge T+1.
- `rspN_valid` is high from cycle T+1 until the edge where `rspN_ready` is sampled high. The earliest such edge is T+2.
- Minimum issue interval is 3 cycles, with zero-wait response.
- With both requesters continuously valid, grants alternate strictly: PRIO_RESET, other, PRIO_RESET, and so on.
- The `alu` is purely combinational, so the EXEC capture has no additional latency.
- An asynchronous `reset_n` assertion clears outputs immediately. Release is synchronized externally by the system.

## Test plan
- Single add: req0 a=5, b=7, cont=010 accepted at edge T. Required: `rsp0_valid` high at T+1 with `rsp_result`=12, zero=0, bge=1; `rsp1_valid` stays 0.
- Subtract and slt:
  - req1 a=3, b=5, cont=110 gives 0xFFFFFFFE, zero=0, bge=0.
  - Then cont=111, a=3, b=5 gives 1, bge=1.
  - Then a=9, b=9, cont=110 gives 0, zero=1.
- Contention: both valid continuously from reset with `PRIO_RESET`=0 and four ops each, `rspN_ready` tied high. Required: owner sequence 0,1,0,1,0,1,0,1, each op 3 cycles apart.
- Back-pressure: `rsp0_ready` held low for 4 cycles after response. Required:
  - Result stable throughout, `busy`=1, `req1_ready`=0 despite `req1_valid`.
  - req1 is granted in the first IDLE cycle after consumption.
- Reset mid-EXEC: assert `reset_n`=0 during EXEC of a req0 op. Required:
  - All ready/valid/busy 0 immediately, and `alu_cont`=000.
  - No `rsp0_valid` after release.
  - The next contention is won by `PRIO_RESET`.
- Unsupported code: req0 cont=011, a=0xFFFF, b=1. Required: result 0, zero=1, bge=1, normal 3-cycle handshake.
